// File: rtl/datamemory_arbiter.sv
// Round-robin arbiter sharing the data-memory port between two requesters,
// with bounded lock ownership and one-cycle-late read response routing.
module datamemory_arbiter #(
  parameter int unsigned ADDRESSWIDTH = 7,
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned LOCK_MAX     = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,

  input  logic                    req0_valid,
  input  logic                    req0_we,
  input  logic                    req0_lock,
  input  logic [ADDRESSWIDTH-1:0] req0_addr,
  input  logic [WIDTH-1:0]        req0_wdata,
  output logic                    req0_ready,
  output logic                    rsp0_valid,
  output logic [WIDTH-1:0]        rsp0_data,

  input  logic                    req1_valid,
  input  logic                    req1_we,
  input  logic                    req1_lock,
  input  logic [ADDRESSWIDTH-1:0] req1_addr,
  input  logic [WIDTH-1:0]        req1_wdata,
  output logic                    req1_ready,
  output logic                    rsp1_valid,
  output logic [WIDTH-1:0]        rsp1_data,

  output logic [ADDRESSWIDTH-1:0] mem_address,
  output logic                    mem_writeEnable,
  output logic [WIDTH-1:0]        mem_dataIn,
  input  logic [WIDTH-1:0]        mem_dataOut
);

  localparam int unsigned     CNT_W      = 8;
  localparam logic [CNT_W-1:0] LOCK_LIMIT = CNT_W'(LOCK_MAX);

  typedef enum logic [1:0] {
    ST_RR    = 2'd0,
    ST_LOCK0 = 2'd1,
    ST_LOCK1 = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
  logic             rsp0_valid_q, rsp0_valid_d;
  logic             rsp1_valid_q, rsp1_valid_d;

  logic gnt0, gnt1;
  logic forced_release;

  // Grant decision; gated by rst_n so nothing reaches the memory during reset.
  // A forced release hands the cycle to the other requester as if in RR.
  always_comb begin
    gnt0           = 1'b0;
    gnt1           = 1'b0;
    forced_release = 1'b0;
    if (rst_n) begin
      case (state_q)
        ST_LOCK0: begin
          if (lock_cnt_q >= LOCK_LIMIT) begin
            forced_release = 1'b1;
            gnt1           = req1_valid;
          end else begin
            gnt0 = req0_valid;
          end
        end
        ST_LOCK1: begin
          if (lock_cnt_q >= LOCK_LIMIT) begin
            forced_release = 1'b1;
            gnt0           = req0_valid;
          end else begin
            gnt1 = req1_valid;
          end
        end
        default: begin
          if (req0_valid && req1_valid) begin
            gnt0 = last_q;
            gnt1 = !last_q;
          end else begin
            gnt0 = req0_valid;
            gnt1 = req1_valid;
          end
        end
      endcase
    end
  end

  // Next-state for lock FSM, round-robin pointer, lock counter and responses.
  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    lock_cnt_d   = lock_cnt_q;
    rsp0_valid_d = gnt0 && !req0_we;
    rsp1_valid_d = gnt1 && !req1_we;

    if (gnt0) begin
      last_d = 1'b0;
    end else if (gnt1) begin
      last_d = 1'b1;
    end

    if ((state_q != ST_RR) && (lock_cnt_q < LOCK_LIMIT)) begin
      lock_cnt_d = lock_cnt_q + CNT_W'(1);
    end

    if (forced_release) begin
      state_d = ST_RR;
    end else if ((state_q == ST_LOCK0) && gnt0 && !req0_lock) begin
      state_d = ST_RR;
    end else if ((state_q == ST_LOCK1) && gnt1 && !req1_lock) begin
      state_d = ST_RR;
    end

    if ((state_q == ST_RR) || forced_release) begin
      if (gnt0 && req0_lock) begin
        state_d = ST_LOCK0;
      end else if (gnt1 && req1_lock) begin
        state_d = ST_LOCK1;
      end
    end

    // Counter restarts on every lock entry and idles at zero in RR.
    if ((state_d == ST_RR) || (state_d != state_q)) begin
      lock_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_RR;
      last_q       <= 1'b1;
      lock_cnt_q   <= '0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      lock_cnt_q   <= lock_cnt_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  assign mem_address     = gnt0 ? req0_addr  : (gnt1 ? req1_addr  : '0);
  assign mem_dataIn      = gnt0 ? req0_wdata : (gnt1 ? req1_wdata : '0);
  assign mem_writeEnable = (gnt0 && req0_we) || (gnt1 && req1_we);

  assign rsp0_valid = rsp0_valid_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp0_data  = mem_dataOut;
  assign rsp1_data  = mem_dataOut;

endmodule

// File: tb/tb_datamemory_arbiter.sv
// Directed bench for datamemory_arbiter: behavioural memory, expected-grant
// stimulus steps and a response scoreboard queue.
module tb_datamemory_arbiter;

  localparam int unsigned AW = 7;
  localparam int unsigned DW = 8;

  logic          clk;
  logic          rst_n;
  logic          req0_valid, req0_we, req0_lock, req0_ready, rsp0_valid;
  logic [AW-1:0] req0_addr;
  logic [DW-1:0] req0_wdata, rsp0_data;
  logic          req1_valid, req1_we, req1_lock, req1_ready, rsp1_valid;
  logic [AW-1:0] req1_addr;
  logic [DW-1:0] req1_wdata, rsp1_data;
  logic [AW-1:0] mem_address;
  logic          mem_writeEnable;
  logic [DW-1:0] mem_dataIn, mem_dataOut;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic          id;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          sb_q[$];
  logic [DW-1:0] mem     [0:(1<<AW)-1];
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];

  datamemory_arbiter #(
    .ADDRESSWIDTH(AW),
    .WIDTH       (DW),
    .LOCK_MAX    (4)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req0_valid     (req0_valid),
    .req0_we        (req0_we),
    .req0_lock      (req0_lock),
    .req0_addr      (req0_addr),
    .req0_wdata     (req0_wdata),
    .req0_ready     (req0_ready),
    .rsp0_valid     (rsp0_valid),
    .rsp0_data      (rsp0_data),
    .req1_valid     (req1_valid),
    .req1_we        (req1_we),
    .req1_lock      (req1_lock),
    .req1_addr      (req1_addr),
    .req1_wdata     (req1_wdata),
    .req1_ready     (req1_ready),
    .rsp1_valid     (rsp1_valid),
    .rsp1_data      (rsp1_data),
    .mem_address    (mem_address),
    .mem_writeEnable(mem_writeEnable),
    .mem_dataIn     (mem_dataIn),
    .mem_dataOut    (mem_dataOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory with registered read data.
  always @(posedge clk) begin
    if (mem_writeEnable) mem[mem_address] <= mem_dataIn;
    mem_dataOut <= mem[mem_address];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle with the expected grants e0/e1 for the currently driven inputs.
  task automatic cycle(input string tag, input logic e0, input logic e1);
    exp_t e;
    @(negedge clk);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check({tag, " rsp0_valid"}, 32'(rsp0_valid), 32'(e.id == 1'b0));
      check({tag, " rsp1_valid"}, 32'(rsp1_valid), 32'(e.id == 1'b1));
      if (e.id == 1'b0) check({tag, " rsp0_data"}, 32'(rsp0_data), 32'(e.data));
      else              check({tag, " rsp1_data"}, 32'(rsp1_data), 32'(e.data));
    end else begin
      check({tag, " rsp0_valid idle"}, 32'(rsp0_valid), 32'd0);
      check({tag, " rsp1_valid idle"}, 32'(rsp1_valid), 32'd0);
    end
    check({tag, " req0_ready"}, 32'(req0_ready), 32'(e0));
    check({tag, " req1_ready"}, 32'(req1_ready), 32'(e1));
    if (e0) begin
      check({tag, " mem_address"}, 32'(mem_address), 32'(req0_addr));
      check({tag, " mem_we"}, 32'(mem_writeEnable), 32'(req0_we));
      if (req0_we) begin
        check({tag, " mem_dataIn"}, 32'(mem_dataIn), 32'(req0_wdata));
        ref_mem[req0_addr] = req0_wdata;
      end else begin
        e.id = 1'b0; e.data = ref_mem[req0_addr];
        sb_q.push_back(e);
      end
    end else if (e1) begin
      check({tag, " mem_address"}, 32'(mem_address), 32'(req1_addr));
      check({tag, " mem_we"}, 32'(mem_writeEnable), 32'(req1_we));
      if (req1_we) begin
        check({tag, " mem_dataIn"}, 32'(mem_dataIn), 32'(req1_wdata));
        ref_mem[req1_addr] = req1_wdata;
      end else begin
        e.id = 1'b1; e.data = ref_mem[req1_addr];
        sb_q.push_back(e);
      end
    end else begin
      check({tag, " mem_we idle"}, 32'(mem_writeEnable), 32'd0);
      check({tag, " mem_address idle"}, 32'(mem_address), 32'd0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(input logic v, input logic we, input logic lk,
                        input logic [AW-1:0] a, input logic [DW-1:0] d);
    req0_valid = v; req0_we = we; req0_lock = lk; req0_addr = a; req0_wdata = d;
  endtask

  task automatic drive1(input logic v, input logic we, input logic lk,
                        input logic [AW-1:0] a, input logic [DW-1:0] d);
    req1_valid = v; req1_we = we; req1_lock = lk; req1_addr = a; req1_wdata = d;
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      mem[i]     = DW'(i * 7 + 3);
      ref_mem[i] = DW'(i * 7 + 3);
    end
    rst_n = 1'b0;
    drive0(1'b1, 1'b1, 1'b0, 7'd1, 8'hFF);
    drive1(1'b1, 1'b1, 1'b0, 7'd2, 8'hEE);
    @(posedge clk);
    #1;

    // Reset held with both requesters writing
    for (int i = 0; i < 3; i++) cycle("reset", 1'b0, 1'b0);
    check("reset mem[1]", 32'(mem[1]), 32'(ref_mem[1]));
    check("reset mem[2]", 32'(mem[2]), 32'(ref_mem[2]));

    // Tie arbitration, both reading continuously
    rst_n = 1'b1;
    drive0(1'b1, 1'b0, 1'b0, 7'd5, 8'h00);
    drive1(1'b1, 1'b0, 1'b0, 7'd9, 8'h00);
    cycle("tie g0a", 1'b1, 1'b0);
    cycle("tie g1a", 1'b0, 1'b1);
    cycle("tie g0b", 1'b1, 1'b0);
    cycle("tie g1b", 1'b0, 1'b1);
    drive0(1'b0, 1'b0, 1'b0, 7'd0, 8'h00);
    drive1(1'b0, 1'b0, 1'b0, 7'd0, 8'h00);
    cycle("tie drain", 1'b0, 1'b0);

    // Write then read the same address
    drive0(1'b1, 1'b1, 1'b0, 7'd3, 8'hA5);
    cycle("wr", 1'b1, 1'b0);
    drive0(1'b1, 1'b0, 1'b0, 7'd3, 8'h00);
    cycle("rd", 1'b1, 1'b0);
    drive0(1'b0, 1'b0, 1'b0, 7'd0, 8'h00);
    cycle("wr_rd rsp", 1'b0, 1'b0);
    check("wr_rd ref", 32'(ref_mem[3]), 32'h0000_00A5);

    // Lock by requester 1 while requester 0 waits
    drive0(1'b1, 1'b0, 1'b0, 7'd5, 8'h00);
    drive1(1'b1, 1'b0, 1'b1, 7'd9, 8'h00);
    cycle("lock1 take", 1'b0, 1'b1);
    drive1(1'b0, 1'b0, 1'b0, 7'd0, 8'h00);
    cycle("lock1 idle1", 1'b0, 1'b0);
    cycle("lock1 idle2", 1'b0, 1'b0);
    drive1(1'b1, 1'b0, 1'b0, 7'd2, 8'h00);
    cycle("lock1 unlock", 1'b0, 1'b1);
    drive1(1'b0, 1'b0, 1'b0, 7'd0, 8'h00);
    cycle("lock1 after", 1'b1, 1'b0);
    drive0(1'b0, 1'b0, 1'b0, 7'd0, 8'h00);
    cycle("lock1 drain", 1'b0, 1'b0);

    // Forced release after LOCK_MAX cycles of requester 0 idling in lock
    drive0(1'b1, 1'b1, 1'b1, 7'd4, 8'h3C);
    cycle("force take", 1'b1, 1'b0);
    drive0(1'b0, 1'b0, 1'b0, 7'd0, 8'h00);
    drive1(1'b1, 1'b0, 1'b0, 7'd9, 8'h00);
    for (int i = 0; i < 4; i++) cycle("force hold", 1'b0, 1'b0);
    cycle("force release", 1'b0, 1'b1);
    drive1(1'b0, 1'b0, 1'b0, 7'd0, 8'h00);
    cycle("force drain", 1'b0, 1'b0);

    // Reset while in LOCK0 with a read response outstanding
    drive0(1'b1, 1'b0, 1'b1, 7'd3, 8'h00);
    cycle("midrst lock", 1'b1, 1'b0);
    rst_n = 1'b0;
    drive0(1'b1, 1'b0, 1'b0, 7'd5, 8'h00);
    drive1(1'b1, 1'b0, 1'b0, 7'd9, 8'h00);
    cycle("midrst assert", 1'b0, 1'b0);
    rst_n = 1'b1;
    cycle("midrst tie0", 1'b1, 1'b0);
    cycle("midrst tie1", 1'b0, 1'b1);
    drive0(1'b0, 1'b0, 1'b0, 7'd0, 8'h00);
    drive1(1'b0, 1'b0, 1'b0, 7'd0, 8'h00);
    cycle("midrst drain", 1'b0, 1'b0);
    check("scoreboard empty", 32'(sb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
